// File: rtl/sar_search.sv
// MSB-first successive-approximation controller. It drives the trial operand of an
// external combinational magnitude comparator and consumes its lt/gt/eq verdict.
module sar_search #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             lt,
   input  logic             gt,
   input  logic             eq,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_dn;
   logic             legal;
   logic [WIDTH-1:0] decided;
   logic [WIDTH-1:0] stepped;

   // decided: trial with bit idx resolved; stepped: next trial with bit idx-1 set
   always_comb begin
      legal   = (lt ^ gt ^ eq) & ~(lt & gt & eq);
      idx_dn  = idx - IW'(1);
      decided = trial;
      if (lt) decided[idx] = 1'b0;
      stepped = decided;
      if (idx != '0) stepped[idx_dn] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         trial  <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= TRY;
                  busy  <= 1'b1;
                  trial <= {1'b1, {(WIDTH-1){1'b0}}};
                  idx   <= IW'(WIDTH-1);
               end
            end
            TRY: begin
               // An illegal verdict reports the trial that provoked it
               if (!legal || eq) begin
                  result <= trial;
                  err    <= ~legal;
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  trial  <= '0;
               end else if (idx == '0) begin
                  result <= decided;
                  err    <= 1'b0;
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  trial  <= '0;
               end else begin
                  trial <= stepped;
                  idx   <= idx_dn;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               trial <= '0;
            end
         endcase
      end
   end

endmodule
